data_mem_ctrl: RTL and testbench

//   Handshaked data memory for the RV32 load/store stage. Word-organised RAM with byte enables and synchronous read.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_bank.sv | 31 +++
 rtl/data_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data memory controller: FSM states, funct3 codes,
// byte-mask and load-extension functions, and the latched request descriptor.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // be/wdat span two words so a split access carries its spill lanes in the upper half
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [7:0]  be;
    logic [63:0] wdat;
    logic        split;
    logic        err;
  } dmem_req_t;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] funct3);
    case (funct3)
      F3_B:    return {{24{data[7]}}, data[7:0]};
      F3_H:    return {{16{data[15]}}, data[15:0]};
      F3_BU:   return {24'd0, data[7:0]};
      F3_HU:   return {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a one-cycle registered read port.
// The array is deliberately not reset.
module dmem_bank #(
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 load/store data memory: one request in flight, 3 edges to response (4 when split),
// response held until rsp_ready; req_ready only while idle.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int XLEN          = 32,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int WA = ADDR_WIDTH - 2;

  if (XLEN != 32) begin : g_xlen_chk
    $error("data_mem_ctrl: only XLEN=32 is supported");
  end
  if (ADDR_WIDTH < 3) begin : g_aw_chk
    $error("data_mem_ctrl: ADDR_WIDTH must be at least 3");
  end

  dmem_state_e   state_q, state_d;
  dmem_req_t     req_q, req_d, dec;
  logic [WA-1:0] word_q, word_d;
  logic [31:0]   lo_q, lo_d, rdata_q, rdata_d;
  logic          valid_q, valid_d, err_q, err_d;

  logic [3:0]    dec_mask;
  logic          misal, illegal, range_err;
  logic [32:0]   last_byte;
  logic [63:0]   merged;
  logic          accept;

  logic          bank_en, bank_we;
  logic [3:0]    bank_be;
  logic [WA-1:0] bank_addr;
  logic [31:0]   bank_wdata, bank_rdata;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Decode of the live request; only latched on acceptance
  always_comb begin
    dec_mask  = size_mask(req_funct3);
    misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_funct3[2] && req_write);
    last_byte = {1'b0, req_addr} + {31'd0, req_funct3[1], req_funct3[1] | req_funct3[0]};
    range_err = (last_byte >> ADDR_WIDTH) != 33'd0;
    dec        = '0;
    dec.write  = req_write;
    dec.funct3 = req_funct3;
    dec.off    = req_addr[1:0];
    dec.be     = {4'b0000, dec_mask} << req_addr[1:0];
    dec.wdat   = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    dec.err    = illegal || range_err || (misal && (MISALIGN_TRAP != 0));
    dec.split  = misal && (MISALIGN_TRAP == 0) && !dec.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      word_q  <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      word_q  <= word_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0:   state_d = req_q.split ? BEAT1 : RESP;
      BEAT1:   state_d = RESP;
      RESP:    if (valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first RESP cycle captures the registered RAM word; valid rises on the following edge
  always_comb begin
    req_d      = req_q;
    word_d     = word_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    err_d      = err_q;
    merged     = '0;
    bank_en    = 1'b0;
    bank_we    = 1'b0;
    bank_be    = 4'b0000;
    bank_addr  = word_q;
    bank_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d  = dec;
          word_d = req_addr[ADDR_WIDTH-1:2];
        end
      end
      BEAT0: begin
        bank_en    = !req_q.err;
        bank_we    = req_q.write;
        bank_be    = req_q.be[3:0];
        bank_wdata = req_q.wdat[31:0];
      end
      BEAT1: begin
        bank_en    = 1'b1;
        bank_we    = req_q.write;
        bank_be    = req_q.be[7:4];
        bank_addr  = word_q + WA'(1);
        bank_wdata = req_q.wdat[63:32];
        lo_d       = bank_rdata;
      end
      RESP: begin
        if (!valid_q) begin
          merged  = req_q.split ? ({bank_rdata, lo_q} >> {req_q.off, 3'b000})
                                : ({32'd0, bank_rdata} >> {req_q.off, 3'b000});
          rdata_d = (req_q.err || req_q.write) ? 32'd0 : extend(merged[31:0], req_q.funct3);
          err_d   = req_q.err;
          valid_d = 1'b1;
        end else if (rsp_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  dmem_bank #(.WORDS(2 ** WA)) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (bank_we),
    .be    (bank_be),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one trapping and one splitting instance share clock, reset and request bus.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_t, req_valid_s;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready;

  logic        req_ready_t, rsp_valid_t, rsp_err_t;
  logic [31:0] rsp_rdata_t;
  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;

  int          sel;
  logic        rdy_m, vld_m, err_m;
  logic [31:0] rd_m;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(10), .XLEN(32), .MISALIGN_TRAP(1)) dut_trap (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_t), .req_ready(req_ready_t), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_t), .rsp_err(rsp_err_t)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .XLEN(32), .MISALIGN_TRAP(0)) dut_split (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s), .req_ready(req_ready_s), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s)
  );

  assign rdy_m = (sel == 0) ? req_ready_t : req_ready_s;
  assign vld_m = (sel == 0) ? rsp_valid_t : rsp_valid_s;
  assign err_m = (sel == 0) ? rsp_err_t   : rsp_err_s;
  assign rd_m  = (sel == 0) ? rsp_rdata_t : rsp_rdata_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic do_txn(input int s, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input string tag);
    int n;
    int lat;
    sel = s;
    @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = 1'b0;
    if (s == 0) req_valid_t = 1'b1; else req_valid_s = 1'b1;
    #1;
    n = 0;
    while (!rdy_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, {31'd0, rdy_m}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_t = 1'b0;
    req_valid_s = 1'b0;
    lat = 1;
    while (!vld_m && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd_m, exp_rd);
    chk({tag, "_err"}, {31'd0, err_m}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_vld"}, {31'd0, vld_m}, 32'd1);
      chk({tag, "_hold_rdata"}, rd_m, exp_rd);
      chk({tag, "_hold_rdy"}, {31'd0, rdy_m}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, vld_m}, 32'd0);
  endtask

  initial begin
    sel         = 0;
    rst_n       = 1'b1;
    req_valid_t = 1'b0;
    req_valid_s = 1'b0;
    req_write   = 1'b0;
    req_funct3  = 3'b010;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready_t}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_t}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_t, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_t}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {31'd0, req_ready_t}, 32'd1);

    // Aligned word store/load and sub-word loads on the trapping instance
    do_txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, 0, "sw_10");
    do_txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, "lw_10");
    do_txn(0, 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 0, "lb_13");
    do_txn(0, 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0, 0, "lbu_13");
    do_txn(0, 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 1'b0, 0, "lh_12");
    do_txn(0, 1'b0, 3'b101, 32'h10, 32'h0, 3, 32'h0000BEEF, 1'b0, 0, "lhu_10");

    // Misalignment traps, range and illegal funct3 faults
    do_txn(0, 1'b0, 3'b010, 32'h11, 32'h0, 3, 32'h0, 1'b1, 0, "lw_11_trap");
    do_txn(0, 1'b1, 3'b001, 32'h13, 32'h5555, 3, 32'h0, 1'b1, 0, "sh_13_trap");
    do_txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, "lw_10_kept");
    do_txn(0, 1'b0, 3'b010, 32'h400, 32'h0, 3, 32'h0, 1'b1, 0, "lw_400_range");
    do_txn(0, 1'b0, 3'b011, 32'h10, 32'h0, 3, 32'h0, 1'b1, 0, "f3_011");
    do_txn(0, 1'b1, 3'b100, 32'h10, 32'h77, 3, 32'h0, 1'b1, 0, "sbu_illegal");

    // Split instance: straddling word store, byte readback, straddling loads
    do_txn(1, 1'b1, 3'b010, 32'h0E, 32'h11223344, 4, 32'h0, 1'b0, 0, "sw_0e_split");
    do_txn(1, 1'b0, 3'b100, 32'h0E, 32'h0, 3, 32'h44, 1'b0, 0, "lbu_0e");
    do_txn(1, 1'b0, 3'b100, 32'h0F, 32'h0, 3, 32'h33, 1'b0, 0, "lbu_0f");
    do_txn(1, 1'b0, 3'b100, 32'h10, 32'h0, 3, 32'h22, 1'b0, 0, "lbu_10");
    do_txn(1, 1'b0, 3'b100, 32'h11, 32'h0, 3, 32'h11, 1'b0, 0, "lbu_11");
    do_txn(1, 1'b0, 3'b010, 32'h0E, 32'h0, 4, 32'h11223344, 1'b0, 0, "lw_0e_split");
    do_txn(1, 1'b0, 3'b001, 32'h0F, 32'h0, 4, 32'h00002233, 1'b0, 0, "lh_0f_split");

    // Top byte: a split into the word past capacity faults and leaves memory alone
    do_txn(1, 1'b1, 3'b000, 32'h3FF, 32'h000000A5, 3, 32'h0, 1'b0, 0, "sb_3ff");
    do_txn(1, 1'b1, 3'b001, 32'h3FF, 32'h0000BBCC, 3, 32'h0, 1'b1, 0, "sh_3ff_wrap");
    do_txn(1, 1'b0, 3'b100, 32'h3FF, 32'h0, 3, 32'hA5, 1'b0, 0, "lbu_3ff");

    // Response backpressure for five cycles
    do_txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 5, "lw_bp");

    // Reset while in BEAT0 aborts the transaction without a response
    sel = 0;
    @(negedge clk);
    req_write   = 1'b0;
    req_funct3  = 3'b010;
    req_addr    = 32'h10;
    req_valid_t = 1'b1;
    @(posedge clk);
    #1;
    req_valid_t = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", {31'd0, rsp_valid_t}, 32'd0);
    chk("midrst_rdy_in_reset", {31'd0, req_ready_t}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rdy_after", {31'd0, req_ready_t}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_rsp", {31'd0, rsp_valid_t}, 32'd0);
    do_txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, "lw_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
